// File: rtl/mil_line_arbiter_if.sv
// Line-arbiter handshake bundle: upstream request, tx/rx line status, grants, pulses and stats.
// The master modport is the arbiter side; the slave modport is the transceiver/queue side.
interface mil_line_arbiter_if;
  logic        txRequest;
  logic        txBusy;
  logic        rxBusy;
  logic        txGrant;
  logic        rxGrant;
  logic        noResponse;
  logic        txWatchdog;
  logic [2:0]  state;
  logic [15:0] statTxBursts;
  logic [15:0] statNoResp;

  modport master (
    input  txRequest, txBusy, rxBusy,
    output txGrant, rxGrant, noResponse, txWatchdog, state, statTxBursts, statNoResp
  );

  modport slave (
    output txRequest, txBusy, rxBusy,
    input  txGrant, rxGrant, noResponse, txWatchdog, state, statTxBursts, statNoResp
  );
endinterface

// File: rtl/mil_line_arbiter.sv
// Half-duplex MIL-STD-1553 line arbiter: inter-message gap, response window, tx watchdog.
// Optional burst/no-response statistics counters are built only when MIL_ARB_STATS_EN is defined.
module mil_line_arbiter #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GAP_CYCLES    = 200,
  parameter int unsigned RESP_TIMEOUT  = 700,
  parameter int unsigned MAX_TX_CYCLES = 40000
) (
  input  logic                 clk,
  input  logic                 rst,
  mil_line_arbiter_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_GAP    = 3'd1,
    TX        = 3'd2,
    RX_WAIT   = 3'd3,
    RX_ACTIVE = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(MAX_TX_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               seen_busy_q, seen_busy_d;
  logic               tx_grant_q, tx_grant_d;
  logic               rx_grant_q, rx_grant_d;
  logic               no_resp_q, no_resp_d;
  logic               tx_wd_q, tx_wd_d;

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    no_resp_d   = 1'b0;
    tx_wd_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rxBusy)         state_d = RX_ACTIVE;
        else if (bus.txRequest) state_d = TX_GAP;
      end
      TX_GAP: begin
        if (bus.rxBusy)          state_d = RX_ACTIVE;
        else if (!bus.txRequest) state_d = IDLE;
        else if (timer_q == GAP_LAST) state_d = TX;
      end
      TX: begin
        if (bus.txBusy) seen_busy_d = 1'b1;
        // Watchdog is checked first so it wins over a same-cycle normal completion.
        if (timer_q == TX_LAST) begin
          tx_wd_d = 1'b1;
          state_d = IDLE;
        end else if (seen_busy_q && !bus.txBusy && !bus.txRequest) begin
          state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (bus.rxBusy) state_d = RX_ACTIVE;
        else if (timer_q == RESP_LAST) begin
          no_resp_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RX_ACTIVE: begin
        if (!bus.rxBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d     = '0;
      seen_busy_d = 1'b0;
    end else if (state_q == TX_GAP || state_q == TX || state_q == RX_WAIT) begin
      timer_d = timer_q + CNT_W'(1);
    end

    tx_grant_d = (state_d == TX);
    rx_grant_d = (state_d == IDLE) || (state_d == RX_WAIT) || (state_d == RX_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      seen_busy_q <= 1'b0;
      tx_grant_q  <= 1'b0;
      rx_grant_q  <= 1'b0;
      no_resp_q   <= 1'b0;
      tx_wd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      seen_busy_q <= seen_busy_d;
      tx_grant_q  <= tx_grant_d;
      rx_grant_q  <= rx_grant_d;
      no_resp_q   <= no_resp_d;
      tx_wd_q     <= tx_wd_d;
    end
  end

  assign bus.txGrant    = tx_grant_q;
  assign bus.rxGrant    = rx_grant_q;
  assign bus.noResponse = no_resp_q;
  assign bus.txWatchdog = tx_wd_q;
  assign bus.state      = state_q;

`ifdef MIL_ARB_STATS_EN
  logic        burst_done;
  logic [15:0] stat_tx_q, stat_tx_d;
  logic [15:0] stat_nr_q, stat_nr_d;

  assign burst_done = (state_q == TX) && (state_d == RX_WAIT);

  always_comb begin
    stat_tx_d = stat_tx_q;
    stat_nr_d = stat_nr_q;
    if (burst_done && stat_tx_q != '1) stat_tx_d = stat_tx_q + 16'd1;
    if (no_resp_d && stat_nr_q != '1)  stat_nr_d = stat_nr_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_tx_q <= '0;
      stat_nr_q <= '0;
    end else begin
      stat_tx_q <= stat_tx_d;
      stat_nr_q <= stat_nr_d;
    end
  end

  assign bus.statTxBursts = stat_tx_q;
  assign bus.statNoResp   = stat_nr_q;
`else
  assign bus.statTxBursts = '0;
  assign bus.statNoResp   = '0;
`endif

endmodule

// File: tb/tb_mil_line_arbiter.sv
// Directed bench for mil_line_arbiter: expected timings are queued when stimulus starts
// and popped when the DUT responds.
module tb_mil_line_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mil_line_arbiter_if bus();

  mil_line_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MIL_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  // From IDLE with txRequest high: edges until txGrant, plus count of cycles
  // where the gap was not quiet (wrong state or rxGrant high).
  task automatic run_gap(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (n < 400) begin
      tick();
      n++;
      if (bus.txGrant === 1'b1) break;
      if (bus.state !== 3'd1 || bus.rxGrant !== 1'b0) bad++;
    end
  endtask

  int n;
  int bad;

  initial begin
    bus.txRequest = 1'b0;
    bus.txBusy    = 1'b0;
    bus.rxBusy    = 1'b0;
    rst           = 1'b1;

    // Reset
    repeat (3) tick();
    check("rst_txgrant", bus.txGrant, 0);
    check("rst_rxgrant", bus.rxGrant, 0);
    check("rst_state", bus.state, 0);
    check("rst_pulses", {bus.noResponse, bus.txWatchdog}, 0);
    check("rst_stats", {bus.statTxBursts, bus.statNoResp}, 0);
    rst = 1'b0;
    tick();
    check("rel_rxgrant", bus.rxGrant, 1);
    check("rel_txgrant", bus.txGrant, 0);
    check("rel_state", bus.state, 0);

    // Gap timing
    bus.txRequest = 1'b1;
    push_exp("gap_edges", 201);
    run_gap(n, bad);
    pop_check(n);
    check("gap_quiet", bad, 0);
    check("gap_state_tx", bus.state, 2);
    check("gap_rxgrant", bus.rxGrant, 0);

    // Burst 1, unanswered
    bus.txBusy = 1'b1;
    repeat (1000) tick();
    check("tx_hold_state", bus.state, 2);
    check("tx_hold_grant", bus.txGrant, 1);
    bus.txBusy    = 1'b0;
    bus.txRequest = 1'b0;
    tick();
    check("rxwait_state", bus.state, 3);
    check("rxwait_grants", {bus.txGrant, bus.rxGrant}, 2'b01);
    push_exp("noresp_edges", 700);
    n = 0;
    while (n < 1000) begin
      tick();
      n++;
      if (bus.noResponse === 1'b1) break;
    end
    pop_check(n);
    check("noresp_state", bus.state, 0);
    check("noresp_rxgrant", bus.rxGrant, 1);
    tick();
    check("noresp_width", bus.noResponse, 0);
    check("stat_tx_1", bus.statTxBursts, STATS ? 1 : 0);
    check("stat_nr_1", bus.statNoResp, STATS ? 1 : 0);

    // Receive preemption during TX_GAP
    bus.txRequest = 1'b1;
    bad = 0;
    tick();
    check("pre_gap_state", bus.state, 1);
    repeat (49) begin
      tick();
      if (bus.txGrant !== 1'b0) bad++;
    end
    bus.rxBusy = 1'b1;
    tick();
    check("pre_rx_state", bus.state, 4);
    check("pre_rx_grant", bus.rxGrant, 1);
    repeat (20) begin
      tick();
      if (bus.txGrant !== 1'b0 || bus.state !== 3'd4) bad++;
    end
    check("pre_tx_never", bad, 0);
    bus.rxBusy = 1'b0;
    tick();
    check("pre_idle", bus.state, 0);
    push_exp("regap_edges", 201);
    run_gap(n, bad);
    pop_check(n);
    check("regap_quiet", bad, 0);

    // TX never saw txBusy: must not complete
    bus.txRequest = 1'b0;
    repeat (5) tick();
    check("noseen_state", bus.state, 2);

    // Burst 2, answered
    bus.txBusy = 1'b1;
    repeat (10) tick();
    bus.txBusy = 1'b0;
    tick();
    check("b2_rxwait", bus.state, 3);
    repeat (5) tick();
    bus.rxBusy = 1'b1;
    tick();
    check("b2_rxactive", bus.state, 4);
    repeat (5) tick();
    bus.rxBusy = 1'b0;
    tick();
    check("b2_idle", bus.state, 0);
    check("stat_tx_2", bus.statTxBursts, STATS ? 2 : 0);
    check("stat_nr_2", bus.statNoResp, STATS ? 1 : 0);

    // Watchdog
    bus.txRequest = 1'b1;
    push_exp("wd_gap_edges", 201);
    run_gap(n, bad);
    pop_check(n);
    bus.txBusy = 1'b1;
    push_exp("wd_edges", 40000);
    n = 0;
    while (n < 41000) begin
      tick();
      n++;
      if (bus.txWatchdog === 1'b1) break;
    end
    pop_check(n);
    check("wd_txgrant", bus.txGrant, 0);
    check("wd_state", bus.state, 0);
    check("wd_rxgrant", bus.rxGrant, 1);
    bus.txRequest = 1'b0;
    bus.txBusy    = 1'b0;
    tick();
    check("wd_width", bus.txWatchdog, 0);
    check("wd_stat_tx", bus.statTxBursts, STATS ? 2 : 0);
    check("wd_stat_nr", bus.statNoResp, STATS ? 1 : 0);

    // Asynchronous reset mid-burst
    bus.txRequest = 1'b1;
    push_exp("ar_gap_edges", 201);
    run_gap(n, bad);
    pop_check(n);
    bus.txBusy = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("ar_grants", {bus.txGrant, bus.rxGrant}, 0);
    check("ar_state", bus.state, 0);
    check("ar_pulses", {bus.noResponse, bus.txWatchdog}, 0);
    check("ar_stats", {bus.statTxBursts, bus.statNoResp}, 0);
    bus.txRequest = 1'b0;
    bus.txBusy    = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("ar_rel_rxgrant", bus.rxGrant, 1);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
